// File: rtl/tl_mst_burst.sv
//==============================================================================
// tl_mst_burst
//------------------------------------------------------------------------------
// TileLink-UH initiator. It turns a simple command / write-stream / read-stream
// interface into PutFullData and Get transactions, including multi-beat bursts
// on the 128-bit A and D channels, and collects the AccessAck / AccessAckData
// responses. It sits between cache or DMA logic and a memory-side TileLink
// slave such as tl_mem.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/ready            command handshake (ready only while idle)
//   cmd_wr                     1 = PutFullData, 0 = Get
//   cmd_addr, cmd_size         base address, log2 of the transfer size in bytes
//   wdata_valid/ready, wdata   write beat stream (passed straight to channel A)
//   rdata_valid/ready, rdata,
//   rdata_last                 read beat stream (passed straight from channel D)
//   resp_valid, resp_err       one-cycle completion pulse and its error flag
//   tlmst_a_*                  TileLink channel A (request) outputs, a_ready in
//   tlmst_d_*                  TileLink channel D (response) inputs, d_ready out
//==============================================================================
module tl_mst_burst #(
    parameter int         DW       = 128,
    parameter int         AW       = 32,
    parameter logic [2:0] SRC_ID   = 3'd0,
    parameter int         MAX_SIZE = 6
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_wr,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [7:0]      cmd_size,

    input  logic            wdata_valid,
    input  logic [DW-1:0]   wdata,
    output logic            wdata_ready,

    output logic            rdata_valid,
    output logic [DW-1:0]   rdata,
    output logic            rdata_last,
    input  logic            rdata_ready,

    output logic            resp_valid,
    output logic            resp_err,

    output logic [2:0]      tlmst_a_opcode,
    output logic [2:0]      tlmst_a_param,
    output logic [7:0]      tlmst_a_size,
    output logic [2:0]      tlmst_a_source,
    output logic [AW-1:0]   tlmst_a_address,
    output logic [15:0]     tlmst_a_mask,
    output logic [DW-1:0]   tlmst_a_data,
    output logic            tlmst_a_corrupt,
    output logic            tlmst_a_valid,
    input  logic            tlmst_a_ready,

    input  logic [2:0]      tlmst_d_opcode,
    input  logic [1:0]      tlmst_d_param,
    input  logic [7:0]      tlmst_d_size,
    input  logic [2:0]      tlmst_d_source,
    input  logic [2:0]      tlmst_d_sink,
    input  logic            tlmst_d_denied,
    input  logic [DW-1:0]   tlmst_d_data,
    input  logic            tlmst_d_corrupt,
    input  logic            tlmst_d_valid,
    output logic            tlmst_d_ready
);

    // TileLink opcodes used by this initiator
    localparam logic [2:0] OP_PUT_FULL  = 3'd0;
    localparam logic [2:0] OP_GET       = 3'd4;
    localparam logic [2:0] OP_ACK       = 3'd0;
    localparam logic [2:0] OP_ACK_DATA  = 3'd1;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        GET_REQ,
        GET_DATA,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      size_q, size_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            ack_seen_q, ack_seen_d;
    logic            err_q, err_d;

    logic [7:0]      beats;
    logic [15:0]     byteMask;
    logic [15:0]     mask;
    logic            illegalSize;
    logic            moreToSend;
    logic            aFire;
    logic [7:0]      sentNow;
    logic            dBeatErr;
    logic            lastBeat;

    // The D-channel routing fields carry nothing this single-source initiator
    // needs; they are folded here so the ports stay connected.
    logic            unusedD;
    assign unusedD = ^{tlmst_d_param, tlmst_d_size, tlmst_d_source, tlmst_d_sink};

    // Fields of channel A that never change for this initiator
    assign tlmst_a_param   = 3'd0;
    assign tlmst_a_corrupt = 1'b0;
    assign tlmst_a_source  = SRC_ID;

    // Number of 16-byte beats in the latched transfer. Sizes of 16 bytes or
    // less always take a single (partially masked) beat. Only legal sizes
    // ever reach the states that use this, so the shift stays small.
    always_comb begin
        if (size_q <= 8'd4) begin
            beats = 8'd1;
        end else begin
            beats = 8'd1 << (size_q - 8'd4);
        end
    end

    // Byte-lane mask: full beat for 16 bytes and up, otherwise 2^size lanes
    // starting at the byte offset inside the beat.
    always_comb begin
        case (size_q[1:0])
            2'd0:    byteMask = 16'h0001;
            2'd1:    byteMask = 16'h0003;
            2'd2:    byteMask = 16'h000F;
            default: byteMask = 16'h00FF;
        endcase
        if (size_q >= 8'd4) begin
            mask = 16'hFFFF;
        end else begin
            mask = byteMask << addr_q[3:0];
        end
    end

    assign illegalSize = (cmd_size > 8'(MAX_SIZE));

    // A D beat is bad if the slave flags it, or if it is not the response
    // opcode expected for the transaction in flight.
    always_comb begin
        dBeatErr = tlmst_d_denied | tlmst_d_corrupt;
        if (state_q == PUT) begin
            dBeatErr = dBeatErr | (tlmst_d_opcode != OP_ACK);
        end else if (state_q == GET_DATA) begin
            dBeatErr = dBeatErr | (tlmst_d_opcode != OP_ACK_DATA);
        end
    end

    // Write-side beat accounting. Once every beat of a Put is out, the write
    // stream is no longer offered to channel A even if wdata_valid stays high.
    assign moreToSend = (cnt_q < beats);
    assign aFire      = tlmst_a_valid & tlmst_a_ready;
    assign sentNow    = cnt_q + {7'd0, aFire};
    assign lastBeat   = (cnt_q == (beats - 8'd1));

    // State register and transaction context
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            cnt_q      <= '0;
            ack_seen_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            ack_seen_q <= ack_seen_d;
            err_q      <= err_d;
        end
    end

    // Next-state and output decode. Channel A address/size/mask are driven
    // from the latched command for every beat of the transaction.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        size_d          = size_q;
        cnt_d           = cnt_q;
        ack_seen_d      = ack_seen_q;
        err_d           = err_q;

        cmd_ready       = 1'b0;
        wdata_ready     = 1'b0;
        rdata_valid     = 1'b0;
        rdata           = '0;
        rdata_last      = 1'b0;
        resp_valid      = 1'b0;
        resp_err        = 1'b0;
        tlmst_a_opcode  = OP_PUT_FULL;
        tlmst_a_size    = size_q;
        tlmst_a_address = addr_q;
        tlmst_a_mask    = mask;
        tlmst_a_data    = '0;
        tlmst_a_valid   = 1'b0;
        tlmst_d_ready   = 1'b1;

        case (state_q)
            // Stray D beats are swallowed here so a misbehaving slave cannot
            // stall the channel.
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    size_d     = cmd_size;
                    cnt_d      = '0;
                    ack_seen_d = 1'b0;
                    err_d      = illegalSize;
                    if (illegalSize) begin
                        state_d = DONE;
                    end else if (cmd_wr) begin
                        state_d = PUT;
                    end else begin
                        state_d = GET_REQ;
                    end
                end
            end

            // The slave may acknowledge before the last data beat has gone
            // out, so the ack is remembered and completion waits for both.
            PUT: begin
                tlmst_a_opcode = OP_PUT_FULL;
                tlmst_a_valid  = wdata_valid & moreToSend;
                wdata_ready    = tlmst_a_ready & moreToSend;
                tlmst_a_data   = wdata;
                if (aFire) begin
                    cnt_d = sentNow;
                end
                if (tlmst_d_valid) begin
                    ack_seen_d = 1'b1;
                    err_d      = err_q | dBeatErr;
                end
                if ((sentNow == beats) && (ack_seen_q || tlmst_d_valid)) begin
                    state_d = DONE;
                end
            end

            GET_REQ: begin
                tlmst_a_opcode = OP_GET;
                tlmst_a_valid  = 1'b1;
                if (tlmst_a_ready) begin
                    state_d = GET_DATA;
                end
            end

            // Read beats flow straight through; backpressure from the read
            // sink is handed directly to the slave.
            GET_DATA: begin
                rdata_valid   = tlmst_d_valid;
                rdata         = tlmst_d_data;
                rdata_last    = lastBeat;
                tlmst_d_ready = rdata_ready;
                if (tlmst_d_valid && rdata_ready) begin
                    cnt_d = cnt_q + 8'd1;
                    err_d = err_q | dBeatErr;
                    if (lastBeat) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tl_mst_burst.sv
//==============================================================================
// tb_tl_mst_burst
//------------------------------------------------------------------------------
// Directed bench for tl_mst_burst. The bench plays both the command source and
// the TileLink slave, driving hand-chosen D responses and checking channel A
// and the stream/response outputs against hand-computed values.
//==============================================================================
module tb_tl_mst_burst;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_wr;
    logic [31:0]     cmd_addr;
    logic [7:0]      cmd_size;
    logic            wdata_valid;
    logic [127:0]    wdata;
    logic            wdata_ready;
    logic            rdata_valid;
    logic [127:0]    rdata;
    logic            rdata_last;
    logic            rdata_ready;
    logic            resp_valid;
    logic            resp_err;
    logic [2:0]      tlmst_a_opcode;
    logic [2:0]      tlmst_a_param;
    logic [7:0]      tlmst_a_size;
    logic [2:0]      tlmst_a_source;
    logic [31:0]     tlmst_a_address;
    logic [15:0]     tlmst_a_mask;
    logic [127:0]    tlmst_a_data;
    logic            tlmst_a_corrupt;
    logic            tlmst_a_valid;
    logic            tlmst_a_ready;
    logic [2:0]      tlmst_d_opcode;
    logic [1:0]      tlmst_d_param;
    logic [7:0]      tlmst_d_size;
    logic [2:0]      tlmst_d_source;
    logic [2:0]      tlmst_d_sink;
    logic            tlmst_d_denied;
    logic [127:0]    tlmst_d_data;
    logic            tlmst_d_corrupt;
    logic            tlmst_d_valid;
    logic            tlmst_d_ready;

    int checks;
    int errors;
    int respCount;
    int aValidCount;

    tl_mst_burst #(
        .DW       (128),
        .AW       (32),
        .SRC_ID   (3'd0),
        .MAX_SIZE (6)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_wr          (cmd_wr),
        .cmd_addr        (cmd_addr),
        .cmd_size        (cmd_size),
        .wdata_valid     (wdata_valid),
        .wdata           (wdata),
        .wdata_ready     (wdata_ready),
        .rdata_valid     (rdata_valid),
        .rdata           (rdata),
        .rdata_last      (rdata_last),
        .rdata_ready     (rdata_ready),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .tlmst_a_opcode  (tlmst_a_opcode),
        .tlmst_a_param   (tlmst_a_param),
        .tlmst_a_size    (tlmst_a_size),
        .tlmst_a_source  (tlmst_a_source),
        .tlmst_a_address (tlmst_a_address),
        .tlmst_a_mask    (tlmst_a_mask),
        .tlmst_a_data    (tlmst_a_data),
        .tlmst_a_corrupt (tlmst_a_corrupt),
        .tlmst_a_valid   (tlmst_a_valid),
        .tlmst_a_ready   (tlmst_a_ready),
        .tlmst_d_opcode  (tlmst_d_opcode),
        .tlmst_d_param   (tlmst_d_param),
        .tlmst_d_size    (tlmst_d_size),
        .tlmst_d_source  (tlmst_d_source),
        .tlmst_d_sink    (tlmst_d_sink),
        .tlmst_d_denied  (tlmst_d_denied),
        .tlmst_d_data    (tlmst_d_data),
        .tlmst_d_corrupt (tlmst_d_corrupt),
        .tlmst_d_valid   (tlmst_d_valid),
        .tlmst_d_ready   (tlmst_d_ready)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts completion pulses and channel-A requests, sampled mid-cycle
    initial begin
        respCount   = 0;
        aValidCount = 0;
        forever begin
            @(negedge clk);
            if (resp_valid) respCount++;
            if (tlmst_a_valid) aValidCount++;
        end
    end

    // Hard stop in case the sequence ever wedges
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic wr,
                                 input logic [31:0] addr, input logic [7:0] size);
        cmd_valid = valid;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_size  = size;
    endtask

    task automatic driveD(input logic valid, input logic [2:0] opcode,
                          input logic denied, input logic [127:0] data);
        tlmst_d_valid  = valid;
        tlmst_d_opcode = opcode;
        tlmst_d_denied = denied;
        tlmst_d_data   = data;
    endtask

    initial begin
        int idx;
        int respBefore;
        int aBefore;
        logic seen;

        checks = 0;
        errors = 0;

        rst_n           = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 8'd0);
        wdata_valid     = 1'b0;
        wdata           = '0;
        rdata_ready     = 1'b0;
        tlmst_a_ready   = 1'b0;
        tlmst_d_param   = 2'd0;
        tlmst_d_size    = 8'd0;
        tlmst_d_source  = 3'd0;
        tlmst_d_sink    = 3'd0;
        tlmst_d_corrupt = 1'b0;
        driveD(1'b0, 3'd0, 1'b0, '0);

        // ---------------- reset state ----------------
        tick();
        tick();
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_a_valid", tlmst_a_valid, 0);
        checkOutput("rst_rdata_valid", rdata_valid, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_err", resp_err, 0);
        checkOutput("rst_d_ready", tlmst_d_ready, 1);
        checkOutput("rst_a_param", tlmst_a_param, 0);
        checkOutput("rst_a_corrupt", tlmst_a_corrupt, 0);
        checkOutput("rst_a_source", tlmst_a_source, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- Put size 5, two beats with a gap ----------------
        applyStimulus(1'b1, 1'b1, 32'h0, 8'd5);
        #1;
        checkOutput("put5_cmd_ready", cmd_ready, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 8'd0);
        tlmst_a_ready = 1'b1;
        wdata_valid   = 1'b1;
        wdata         = 128'd1;
        #1;
        checkOutput("put5_b0_valid", tlmst_a_valid, 1);
        checkOutput("put5_b0_opcode", tlmst_a_opcode, 0);
        checkOutput("put5_b0_size", tlmst_a_size, 5);
        checkOutput("put5_b0_mask", tlmst_a_mask, 16'hFFFF);
        checkOutput("put5_b0_addr", tlmst_a_address, 0);
        checkOutput("put5_b0_data", tlmst_a_data, 1);
        checkOutput("put5_wdata_ready", wdata_ready, 1);
        checkOutput("put5_cmd_busy", cmd_ready, 0);
        tick();
        wdata_valid = 1'b0;
        #1;
        checkOutput("put5_gap_valid", tlmst_a_valid, 0);
        tick();
        wdata_valid = 1'b1;
        wdata       = 128'd2;
        #1;
        checkOutput("put5_b1_valid", tlmst_a_valid, 1);
        checkOutput("put5_b1_data", tlmst_a_data, 2);
        checkOutput("put5_b1_mask", tlmst_a_mask, 16'hFFFF);
        tick();
        wdata_valid = 1'b0;
        driveD(1'b1, 3'd0, 1'b0, '0);
        #1;
        checkOutput("put5_wait_a_valid", tlmst_a_valid, 0);
        checkOutput("put5_wait_resp", resp_valid, 0);
        checkOutput("put5_d_ready", tlmst_d_ready, 1);
        tick();
        driveD(1'b0, 3'd0, 1'b0, '0);
        #1;
        checkOutput("put5_resp_valid", resp_valid, 1);
        checkOutput("put5_resp_err", resp_err, 0);
        tick();
        checkOutput("put5_resp_once", resp_valid, 0);
        checkOutput("put5_back_idle", cmd_ready, 1);

        // ---------------- Get size 5, reads back 1 then 2 ----------------
        applyStimulus(1'b1, 1'b0, 32'h0, 8'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 8'd0);
        #1;
        checkOutput("get5_a_valid", tlmst_a_valid, 1);
        checkOutput("get5_a_opcode", tlmst_a_opcode, 4);
        checkOutput("get5_a_size", tlmst_a_size, 5);
        checkOutput("get5_a_data", tlmst_a_data, 0);
        tick();
        rdata_ready = 1'b1;
        driveD(1'b1, 3'd1, 1'b0, 128'd1);
        #1;
        checkOutput("get5_a_single", tlmst_a_valid, 0);
        checkOutput("get5_r0_valid", rdata_valid, 1);
        checkOutput("get5_r0_data", rdata, 1);
        checkOutput("get5_r0_last", rdata_last, 0);
        tick();
        driveD(1'b1, 3'd1, 1'b0, 128'd2);
        #1;
        checkOutput("get5_r1_data", rdata, 2);
        checkOutput("get5_r1_last", rdata_last, 1);
        tick();
        driveD(1'b0, 3'd0, 1'b0, '0);
        #1;
        checkOutput("get5_resp_valid", resp_valid, 1);
        checkOutput("get5_resp_err", resp_err, 0);
        tick();

        // ---------------- Get size 6 with toggling rdata_ready ----------------
        applyStimulus(1'b1, 1'b0, 32'h40, 8'd6);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 8'd0);
        tick();
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            rdata_ready = cyc[0];
            driveD(1'b1, 3'd1, 1'b0, 128'hA0 + 128'(idx));
            #1;
            checkOutput("get6_d_ready", tlmst_d_ready, rdata_ready);
            checkOutput("get6_rdata", rdata, 128'hA0 + 128'(idx));
            if (rdata_ready) begin
                checkOutput("get6_last", rdata_last, (idx == 3));
                idx++;
            end
            tick();
        end
        driveD(1'b0, 3'd0, 1'b0, '0);
        rdata_ready = 1'b0;
        #1;
        checkOutput("get6_beats", idx, 4);
        checkOutput("get6_resp_valid", resp_valid, 1);
        checkOutput("get6_resp_err", resp_err, 0);
        tick();

        // ------- Put size 2 at 0x6, ack with denied in the same cycle -------
        applyStimulus(1'b1, 1'b1, 32'h6, 8'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 8'd0);
        wdata_valid = 1'b1;
        wdata       = 128'hDEAD;
        driveD(1'b1, 3'd0, 1'b1, '0);
        #1;
        checkOutput("put2_valid", tlmst_a_valid, 1);
        checkOutput("put2_mask", tlmst_a_mask, 16'h03C0);
        checkOutput("put2_size", tlmst_a_size, 2);
        checkOutput("put2_addr", tlmst_a_address, 32'h6);
        tick();
        wdata_valid = 1'b0;
        driveD(1'b0, 3'd0, 1'b0, '0);
        #1;
        checkOutput("put2_resp_valid", resp_valid, 1);
        checkOutput("put2_resp_err", resp_err, 1);
        tick();

        // ---------------- illegal size 7: no TileLink traffic ----------------
        aBefore = aValidCount;
        applyStimulus(1'b1, 1'b1, 32'h0, 8'd7);
        wdata_valid = 1'b1;
        #1;
        checkOutput("ill_a_valid_idle", tlmst_a_valid, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 8'd0);
        seen = 1'b0;
        for (int w = 0; w < 4 && !seen; w++) begin
            checkOutput("ill_no_a_valid", tlmst_a_valid, 0);
            if (resp_valid) begin
                seen = 1'b1;
                checkOutput("ill_resp_err", resp_err, 1);
            end
            tick();
        end
        wdata_valid = 1'b0;
        checkOutput("ill_resp_seen", seen, 1);
        checkOutput("ill_a_count", aValidCount - aBefore, 0);
        tick();

        // ------- Get size 3 at 0x4, slave answers with the wrong opcode -------
        applyStimulus(1'b1, 1'b0, 32'h4, 8'd3);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 8'd0);
        #1;
        checkOutput("get3_mask", tlmst_a_mask, 16'h0FF0);
        checkOutput("get3_opcode", tlmst_a_opcode, 4);
        tick();
        rdata_ready = 1'b1;
        driveD(1'b1, 3'd0, 1'b0, 128'h55);
        #1;
        checkOutput("get3_last", rdata_last, 1);
        tick();
        driveD(1'b0, 3'd0, 1'b0, '0);
        #1;
        checkOutput("get3_resp_valid", resp_valid, 1);
        checkOutput("get3_resp_err", resp_err, 1);
        tick();

        // ------- reset in the middle of a 4-beat Put, then a clean Get -------
        respBefore = respCount;
        applyStimulus(1'b1, 1'b1, 32'h80, 8'd6);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 8'd0);
        wdata_valid = 1'b1;
        wdata       = 128'd5;
        #1;
        checkOutput("abort_b0_valid", tlmst_a_valid, 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("abort_a_valid", tlmst_a_valid, 0);
        checkOutput("abort_wdata_ready", wdata_ready, 0);
        checkOutput("abort_cmd_ready", cmd_ready, 1);
        checkOutput("abort_resp_valid", resp_valid, 0);
        checkOutput("abort_rdata_valid", rdata_valid, 0);
        tick();
        tick();
        wdata_valid = 1'b0;
        checkOutput("abort_no_resp", respCount - respBefore, 0);

        applyStimulus(1'b1, 1'b0, 32'h0, 8'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 8'd0);
        #1;
        checkOutput("post_a_valid", tlmst_a_valid, 1);
        checkOutput("post_a_opcode", tlmst_a_opcode, 4);
        checkOutput("post_a_mask", tlmst_a_mask, 16'hFFFF);
        tick();
        rdata_ready = 1'b1;
        driveD(1'b1, 3'd1, 1'b0, 128'h77);
        #1;
        checkOutput("post_rdata", rdata, 128'h77);
        checkOutput("post_last", rdata_last, 1);
        tick();
        driveD(1'b0, 3'd0, 1'b0, '0);
        #1;
        checkOutput("post_resp_valid", resp_valid, 1);
        checkOutput("post_resp_err", resp_err, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
